// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline stages.
//   alu_op_t / ALU_*  : 3-bit ALU operation codes
//   REGW              : register-index width
//   ctrl_t            : decoded control word carried through ID/EX
//   BUBBLE_CTRL       : control word of an empty (bubble) slot
package pipe_pkg;

  localparam int REGW = 5;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_SLT = 3'b100;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
    logic regdst;
  } ctrl_t;

  // A bubble has no side effects: nothing is written and memory is untouched.
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: every non-clock signal of the ID/EX stage.
//   flush, hold              : pipeline control from branch unit / outer freeze
//   id_*                     : decoded operands, indices and controls from ID
//   exmem_*, memwb_*         : the two forwarding sources
//   load_use_stall           : hazard request back to PC and IF/ID
//   alu_*, ex_*              : EX-stage operands, controls and destination
// master drives the ID/forwarding side, slave is the ID/EX stage itself.
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = pipe_pkg::REGW
);
  import pipe_pkg::*;

  logic             flush;
  logic             hold;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic [REGW-1:0]  id_rs;
  logic [REGW-1:0]  id_rt;
  logic [REGW-1:0]  id_rd;
  alu_op_t          id_aluctr;
  logic             id_alusrc;
  logic             id_regdst;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  logic             id_memtoreg;
  logic             exmem_regwrite;
  logic [REGW-1:0]  exmem_rd;
  logic [WIDTH-1:0] exmem_result;
  logic             memwb_regwrite;
  logic [REGW-1:0]  memwb_rd;
  logic [WIDTH-1:0] memwb_data;

  logic             load_use_stall;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alu_op_t          alu_ctr;
  logic [WIDTH-1:0] ex_store_data;
  logic [REGW-1:0]  ex_wreg;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_memwrite;
  logic             ex_memtoreg;
  logic             ex_valid;

  modport master (
    output flush, hold, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_aluctr, id_alusrc, id_regdst, id_regwrite, id_memread,
           id_memwrite, id_memtoreg, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_data,
    input  load_use_stall, alu_a, alu_b, alu_ctr, ex_store_data, ex_wreg,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid
  );

  modport slave (
    input  flush, hold, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_aluctr, id_alusrc, id_regdst, id_regwrite, id_memread,
           id_memwrite, id_memtoreg, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_data,
    output load_use_stall, alu_a, alu_b, alu_ctr, ex_store_data, ex_wreg,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks the freshest value of one source register.
//   reg_idx_i, reg_val_i   : register index and the value latched in ID/EX
//   exmem_*_i              : newest producer (instruction one ahead)
//   memwb_*_i              : older producer (instruction two ahead)
//   fwd_val_o              : value the EX stage must use
module fwd_mux #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic [REGW-1:0]  reg_idx_i,
  input  logic [WIDTH-1:0] reg_val_i,
  input  logic             exmem_regwrite_i,
  input  logic [REGW-1:0]  exmem_rd_i,
  input  logic [WIDTH-1:0] exmem_result_i,
  input  logic             memwb_regwrite_i,
  input  logic [REGW-1:0]  memwb_rd_i,
  input  logic [WIDTH-1:0] memwb_data_i,
  output logic [WIDTH-1:0] fwd_val_o
);

  logic exmem_hit;
  logic memwb_hit;

  // $0 is hard-wired zero, so a "write" to it must never be forwarded.
  assign exmem_hit = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == reg_idx_i);
  assign memwb_hit = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == reg_idx_i);

  // EX/MEM is checked first because it holds the more recent write.
  always_comb begin
    fwd_val_o = reg_val_i;
    if (exmem_hit) begin
      fwd_val_o = exmem_result_i;
    end else if (memwb_hit) begin
      fwd_val_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding and load-use detection.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : id_ex_stage_if slave port (ID inputs, forwarding sources,
//           flush/hold, ALU operands, EX controls, load_use_stall)
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = pipe_pkg::REGW
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  import pipe_pkg::*;

  logic [WIDTH-1:0] rs_data_q, rs_data_d;
  logic [WIDTH-1:0] rt_data_q, rt_data_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [REGW-1:0]  rs_q, rs_d;
  logic [REGW-1:0]  rt_q, rt_d;
  logic [REGW-1:0]  rd_q, rd_d;
  ctrl_t            ctrl_q, ctrl_d;
  alu_op_t          aluctr_q, aluctr_d;
  logic             valid_q, valid_d;

  ctrl_t            id_ctrl;
  logic [REGW-1:0]  wreg;
  logic             stall;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  assign id_ctrl = '{regwrite: bus.id_regwrite,
                     memread:  bus.id_memread,
                     memwrite: bus.id_memwrite,
                     memtoreg: bus.id_memtoreg,
                     alusrc:   bus.id_alusrc,
                     regdst:   bus.id_regdst};

  assign wreg = ctrl_q.regdst ? rd_q : rt_q;

  // A load in EX whose destination is read by the instruction in ID cannot
  // be forwarded in time; the dependent instruction must wait one cycle.
  assign stall = ctrl_q.memread && valid_q && (wreg != '0) &&
                 ((wreg == bus.id_rs) || (wreg == bus.id_rt));

  // Next slot contents. Bubbles only clear controls and valid; the data
  // fields keep their old values since nothing downstream consumes them.
  always_comb begin
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    aluctr_d  = aluctr_q;
    valid_d   = valid_q;
    if (bus.flush || (!bus.hold && stall)) begin
      ctrl_d   = BUBBLE_CTRL;
      aluctr_d = ALU_ADD;
      valid_d  = 1'b0;
    end else if (!bus.hold) begin
      rs_data_d = bus.id_rs_data;
      rt_data_d = bus.id_rt_data;
      imm_d     = bus.id_imm;
      rs_d      = bus.id_rs;
      rt_d      = bus.id_rt;
      rd_d      = bus.id_rd;
      ctrl_d    = id_ctrl;
      aluctr_d  = bus.id_aluctr;
      valid_d   = 1'b1;
    end
  end

  // Slot register; reset clears every field including the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= BUBBLE_CTRL;
      aluctr_q  <= ALU_ADD;
      valid_q   <= 1'b0;
    end else begin
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      aluctr_q  <= aluctr_d;
      valid_q   <= valid_d;
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_rs (
    .reg_idx_i        (rs_q),
    .reg_val_i        (rs_data_q),
    .exmem_regwrite_i (bus.exmem_regwrite),
    .exmem_rd_i       (bus.exmem_rd),
    .exmem_result_i   (bus.exmem_result),
    .memwb_regwrite_i (bus.memwb_regwrite),
    .memwb_rd_i       (bus.memwb_rd),
    .memwb_data_i     (bus.memwb_data),
    .fwd_val_o        (fwd_rs)
  );

  fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_rt (
    .reg_idx_i        (rt_q),
    .reg_val_i        (rt_data_q),
    .exmem_regwrite_i (bus.exmem_regwrite),
    .exmem_rd_i       (bus.exmem_rd),
    .exmem_result_i   (bus.exmem_result),
    .memwb_regwrite_i (bus.memwb_regwrite),
    .memwb_rd_i       (bus.memwb_rd),
    .memwb_data_i     (bus.memwb_data),
    .fwd_val_o        (fwd_rt)
  );

  // Store data always takes the forwarded rt, even when the ALU uses imm.
  assign bus.load_use_stall = stall;
  assign bus.alu_a          = fwd_rs;
  assign bus.alu_b          = ctrl_q.alusrc ? imm_q : fwd_rt;
  assign bus.alu_ctr        = aluctr_q;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.ex_wreg        = wreg;
  assign bus.ex_regwrite    = ctrl_q.regwrite;
  assign bus.ex_memread     = ctrl_q.memread;
  assign bus.ex_memwrite    = ctrl_q.memwrite;
  assign bus.ex_memtoreg    = ctrl_q.memtoreg;
  assign bus.ex_valid       = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic for id_ex_stage,
// compared every cycle against a slot-level reference model.
module tb_id_ex_stage;

  typedef struct {
    bit          rst, flush, hold;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  aluctr;
    bit          alusrc, regdst, regwrite, memread, memwrite, memtoreg;
    bit          ex_rw;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    bit          wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } stim_t;

  typedef struct {
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  aluctr;
    bit          alusrc, regdst, regwrite, memread, memwrite, memtoreg;
    bit          valid;
    bit          known;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst;
  stim_t stim;
  slot_t m;
  int    checks = 0;
  int    errors = 0;

  id_ex_stage_if #(.WIDTH(32), .REGW(5)) bus ();

  id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearStim();
    stim = '{default: 0};
  endtask

  // Drive the current stimulus just after the falling edge and let it settle.
  task automatic applyStimulus();
    @(negedge clk);
    rst                = stim.rst;
    bus.flush          = stim.flush;
    bus.hold           = stim.hold;
    bus.id_rs_data     = stim.rs_data;
    bus.id_rt_data     = stim.rt_data;
    bus.id_imm         = stim.imm;
    bus.id_rs          = stim.rs;
    bus.id_rt          = stim.rt;
    bus.id_rd          = stim.rd;
    bus.id_aluctr      = stim.aluctr;
    bus.id_alusrc      = stim.alusrc;
    bus.id_regdst      = stim.regdst;
    bus.id_regwrite    = stim.regwrite;
    bus.id_memread     = stim.memread;
    bus.id_memwrite    = stim.memwrite;
    bus.id_memtoreg    = stim.memtoreg;
    bus.exmem_regwrite = stim.ex_rw;
    bus.exmem_rd       = stim.ex_rd;
    bus.exmem_result   = stim.ex_res;
    bus.memwb_regwrite = stim.wb_rw;
    bus.memwb_rd       = stim.wb_rd;
    bus.memwb_data     = stim.wb_data;
    #1;
  endtask

  function automatic logic [4:0] refWreg();
    return m.regdst ? m.rd : m.rt;
  endfunction

  function automatic bit refStall();
    logic [4:0] w;
    w = refWreg();
    return m.memread && m.valid && (w != 5'd0) && (w == stim.rs || w == stim.rt);
  endfunction

  function automatic logic [31:0] refFwd(input logic [4:0] idx, input logic [31:0] val);
    if (stim.ex_rw && stim.ex_rd != 5'd0 && stim.ex_rd == idx) return stim.ex_res;
    if (stim.wb_rw && stim.wb_rd != 5'd0 && stim.wb_rd == idx) return stim.wb_data;
    return val;
  endfunction

  task automatic checkModel();
    logic [31:0] rtv;
    checkOutput("stall",    32'(bus.load_use_stall), 32'(refStall()));
    checkOutput("valid",    32'(bus.ex_valid),       32'(m.valid));
    checkOutput("regwrite", 32'(bus.ex_regwrite),    32'(m.regwrite));
    checkOutput("memread",  32'(bus.ex_memread),     32'(m.memread));
    checkOutput("memwrite", 32'(bus.ex_memwrite),    32'(m.memwrite));
    checkOutput("memtoreg", 32'(bus.ex_memtoreg),    32'(m.memtoreg));
    checkOutput("alu_ctr",  32'(bus.alu_ctr),        32'(m.aluctr));
    if (m.known) begin
      rtv = refFwd(m.rt, m.rt_data);
      checkOutput("alu_a",      bus.alu_a,         refFwd(m.rs, m.rs_data));
      checkOutput("alu_b",      bus.alu_b,         m.alusrc ? m.imm : rtv);
      checkOutput("store_data", bus.ex_store_data, rtv);
      checkOutput("wreg",       32'(bus.ex_wreg),  32'(refWreg()));
    end
  endtask

  task automatic makeBubble();
    m.regwrite = 0; m.memread = 0; m.memwrite = 0; m.memtoreg = 0;
    m.alusrc = 0; m.regdst = 0; m.aluctr = 3'b000; m.valid = 0; m.known = 0;
  endtask

  // Advance one rising edge and apply the slot priority rules to the model.
  task automatic clockEdge();
    bit st;
    st = refStall();
    @(posedge clk);
    if (stim.rst) begin
      m = '{default: 0};
      m.known = 1;
    end else if (stim.flush) begin
      makeBubble();
    end else if (stim.hold) begin
      m = m;
    end else if (st) begin
      makeBubble();
    end else begin
      m.rs_data = stim.rs_data; m.rt_data = stim.rt_data; m.imm = stim.imm;
      m.rs = stim.rs; m.rt = stim.rt; m.rd = stim.rd; m.aluctr = stim.aluctr;
      m.alusrc = stim.alusrc; m.regdst = stim.regdst; m.regwrite = stim.regwrite;
      m.memread = stim.memread; m.memwrite = stim.memwrite; m.memtoreg = stim.memtoreg;
      m.valid = 1; m.known = 1;
    end
  endtask

  task automatic stepCycle();
    applyStimulus();
    checkModel();
    clockEdge();
  endtask

  task automatic loadWord4();
    clearStim();
    stim.memread = 1; stim.regwrite = 1; stim.memtoreg = 1; stim.alusrc = 1;
    stim.rs = 5'd1; stim.rt = 5'd4; stim.imm = 32'd4;
    stepCycle();
  endtask

  initial begin
    m = '{default: 0};
    clearStim();
    stim.rst = 1;
    applyStimulus();
    clockEdge();
    stepCycle();

    // Reset state.
    clearStim();
    applyStimulus();
    checkOutput("rst_alu_a",  bus.alu_a, 32'd0);
    checkOutput("rst_valid",  32'(bus.ex_valid), 32'd0);
    checkOutput("rst_aluctr", 32'(bus.alu_ctr), 32'd0);
    checkOutput("rst_stall",  32'(bus.load_use_stall), 32'd0);
    checkModel(); clockEdge();

    // Plain capture.
    clearStim();
    stim.rs_data = 32'd5; stim.rt_data = 32'd7; stim.rs = 5'd1; stim.rt = 5'd2;
    stim.rd = 5'd3; stim.regdst = 1; stim.regwrite = 1;
    stepCycle();
    clearStim();
    applyStimulus();
    checkOutput("cap_alu_a", bus.alu_a, 32'd5);
    checkOutput("cap_alu_b", bus.alu_b, 32'd7);
    checkOutput("cap_valid", 32'(bus.ex_valid), 32'd1);
    checkOutput("cap_wreg",  32'(bus.ex_wreg), 32'd3);
    checkModel(); clockEdge();

    // EX/MEM beats MEM/WB, then MEM/WB alone.
    clearStim();
    stim.rs = 5'd3; stim.rs_data = 32'h99;
    stepCycle();
    clearStim();
    stim.hold = 1; stim.ex_rw = 1; stim.ex_rd = 5'd3; stim.ex_res = 32'h10;
    stim.wb_rw = 1; stim.wb_rd = 5'd3; stim.wb_data = 32'h20;
    applyStimulus();
    checkOutput("fwd_exmem", bus.alu_a, 32'h10);
    checkModel(); clockEdge();
    stim.ex_rd = 5'd0;
    applyStimulus();
    checkOutput("fwd_memwb", bus.alu_a, 32'h20);
    checkModel(); clockEdge();

    // Load-use: one bubble, then the stall drops.
    loadWord4();
    clearStim();
    stim.rs = 5'd5; stim.rt = 5'd4;
    applyStimulus();
    checkOutput("lu_stall", 32'(bus.load_use_stall), 32'd1);
    checkOutput("lu_wreg",  32'(bus.ex_wreg), 32'd4);
    checkModel(); clockEdge();
    clearStim();
    applyStimulus();
    checkOutput("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("lu_bubble_mr",    32'(bus.ex_memread), 32'd0);
    checkOutput("lu_bubble_rw",    32'(bus.ex_regwrite), 32'd0);
    checkOutput("lu_stall_drop",   32'(bus.load_use_stall), 32'd0);
    checkModel(); clockEdge();

    // Flush together with a load-use: a single bubble.
    loadWord4();
    clearStim();
    stim.rs = 5'd4; stim.flush = 1;
    applyStimulus();
    checkOutput("fl_stall", 32'(bus.load_use_stall), 32'd1);
    checkModel(); clockEdge();
    clearStim();
    stim.rs = 5'd6; stim.rs_data = 32'h11; stim.regwrite = 1;
    applyStimulus();
    checkOutput("fl_bubble", 32'(bus.ex_valid), 32'd0);
    checkOutput("fl_nostall", 32'(bus.load_use_stall), 32'd0);
    checkModel(); clockEdge();
    clearStim();
    applyStimulus();
    checkOutput("fl_next_valid", 32'(bus.ex_valid), 32'd1);
    checkOutput("fl_next_a", bus.alu_a, 32'h11);
    checkModel(); clockEdge();

    // $0 never forwards and never stalls.
    clearStim();
    stepCycle();
    clearStim();
    stim.hold = 1; stim.ex_rw = 1; stim.ex_rd = 5'd0; stim.ex_res = 32'hFFFF;
    applyStimulus();
    checkOutput("r0_fwd", bus.alu_a, 32'd0);
    checkModel(); clockEdge();
    clearStim();
    stim.memread = 1; stim.regwrite = 1;
    stepCycle();
    clearStim();
    applyStimulus();
    checkOutput("r0_stall", 32'(bus.load_use_stall), 32'd0);
    checkModel(); clockEdge();

    // sw with immediate, rt forwarded from MEM/WB, then reset.
    clearStim();
    stim.alusrc = 1; stim.imm = 32'd8; stim.rt = 5'd9; stim.rt_data = 32'd1;
    stim.rs = 5'd2; stim.rs_data = 32'd3; stim.memwrite = 1;
    stepCycle();
    clearStim();
    stim.hold = 1; stim.wb_rw = 1; stim.wb_rd = 5'd9; stim.wb_data = 32'h55;
    applyStimulus();
    checkOutput("sw_alu_b", bus.alu_b, 32'd8);
    checkOutput("sw_store", bus.ex_store_data, 32'h55);
    checkModel(); clockEdge();
    clearStim();
    stim.rst = 1; stim.regwrite = 1; stim.memread = 1; stim.rs_data = 32'h77;
    stepCycle();
    clearStim();
    applyStimulus();
    checkOutput("rst2_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("rst2_rw",    32'(bus.ex_regwrite), 32'd0);
    checkOutput("rst2_mr",    32'(bus.ex_memread), 32'd0);
    checkModel(); clockEdge();

    // Hold with a pending load-use keeps the stall up.
    loadWord4();
    clearStim();
    stim.rt = 5'd4; stim.hold = 1;
    repeat (2) begin
      applyStimulus();
      checkOutput("hold_stall", 32'(bus.load_use_stall), 32'd1);
      checkOutput("hold_mr",    32'(bus.ex_memread), 32'd1);
      checkModel(); clockEdge();
    end
    stim.hold = 0;
    stepCycle();
    clearStim();
    applyStimulus();
    checkOutput("hold_bubble", 32'(bus.ex_valid), 32'd0);
    checkModel(); clockEdge();

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      stim.rst      = ($urandom_range(0, 63) == 0);
      stim.flush    = ($urandom_range(0, 9) == 0);
      stim.hold     = ($urandom_range(0, 7) == 0);
      stim.rs_data  = $urandom;
      stim.rt_data  = $urandom;
      stim.imm      = $urandom;
      stim.rs       = 5'($urandom_range(0, 7));
      stim.rt       = 5'($urandom_range(0, 7));
      stim.rd       = 5'($urandom_range(0, 7));
      stim.aluctr   = 3'($urandom_range(0, 4));
      stim.alusrc   = 1'($urandom_range(0, 1));
      stim.regdst   = 1'($urandom_range(0, 1));
      stim.regwrite = 1'($urandom_range(0, 1));
      stim.memread  = 1'($urandom_range(0, 1));
      stim.memwrite = 1'($urandom_range(0, 1));
      stim.memtoreg = 1'($urandom_range(0, 1));
      stim.ex_rw    = 1'($urandom_range(0, 1));
      stim.ex_rd    = 5'($urandom_range(0, 7));
      stim.ex_res   = $urandom;
      stim.wb_rw    = 1'($urandom_range(0, 1));
      stim.wb_rd    = 5'($urandom_range(0, 7));
      stim.wb_data  = $urandom;
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
